execute_fsm: RTL and testbench

- Control FSM for the execute stage of the microcontroller. It sits directly downstream of the instruction-fetch controller.
- Starts when fetch raises done_fetch, then decodes the instruction register.
- Sequences the single shared bus, register file, ALU, MAR/MDR and memory handshake for one instruction.
- Pulses done to return control to fetch.

---
 rtl/exec_pkg.sv | 48 ++++
 rtl/mem_wait_timer.sv | 34 +++
 rtl/execute_fsm.sv | 168 ++++++++++++++++
 tb/tb_execute_fsm.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared opcode, field, ALU and state definitions for the execute stage.
// The fetch controller imports the opcode and field constants from here too.
package exec_pkg;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LOAD  = 4'd1;
  localparam logic [3:0] OP_STORE = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_LDI   = 4'd7;
  localparam logic [3:0] OP_JMP   = 4'd8;
  localparam logic [3:0] OP_HALT  = 4'd15;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_DECODE,
    S_LD1, S_LD2, S_LD3,
    S_ST1, S_ST2, S_ST3,
    S_AL1, S_AL2, S_AL3,
    S_LDI, S_JMP, S_DONE,
    S_HALTED, S_FAULT
  } state_e;

  function automatic logic [1:0] alu_fn(input logic [3:0] opc);
    case (opc)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Bounded wait for the memory handshake: acks on MFC, flags timeout after
// TIMEOUT cycles enabled without MFC. MFC wins over timeout on the same cycle.
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  input  logic mfc_i,
  output logic ack_o,
  output logic timeout_o
);

  localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                                  cnt_d = '0;
    else if (en_i && !mfc_i && (cnt_q != LAST)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign ack_o     = en_i & mfc_i;
  assign timeout_o = en_i & ~mfc_i & (cnt_q == LAST);

endmodule

// File: rtl/execute_fsm.sv
// Execute-stage control FSM: decodes the IR handed over by fetch, sequences
// bus/regfile/ALU/memory strobes for one instruction, then pulses done.
module execute_fsm
  import exec_pkg::*;
#(
  parameter int IR_W    = 16,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            done_fetch,
  input  logic [IR_W-1:0] ir,
  input  logic            MFC,
  output logic            ir_addr_out_en,
  output logic [1:0]      reg_sel,
  output logic            reg_out_en,
  output logic            reg_in,
  output logic            alu_a_in,
  output logic [1:0]      alu_op,
  output logic            alu_z_in,
  output logic            alu_out_en,
  output logic            MARin,
  output logic            EN,
  output logic            RW,
  output logic            MDR_tobusin,
  output logic            MDR_frombusin,
  output logic            MDROutEn,
  output logic            PCin,
  output logic            done,
  output logic            halted,
  output logic            fault
);

  state_e     state_q, state_d;
  logic [3:0] opcode_q;
  logic [1:0] rd_q, rs_q;
  logic       wait_en, mem_ack, mem_timeout;

  // The immediate is routed onto the bus by the datapath, not used here.
  logic [IR_W-1:0] unused_ir;
  assign unused_ir = {ir[IR_W-1:OPC_LSB], ir[RD_MSB:RS_LSB], ir[IMM_MSB:IMM_LSB]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      rd_q     <= '0;
      rs_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && done_fetch) begin
        opcode_q <= ir[OPC_MSB:OPC_LSB];
        rd_q     <= ir[RD_MSB:RD_LSB];
        rs_q     <= ir[RS_MSB:RS_LSB];
      end
    end
  end

  assign wait_en = (state_q == S_LD2) || (state_q == S_ST3);

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (!wait_en),
    .en_i      (wait_en),
    .mfc_i     (MFC),
    .ack_o     (mem_ack),
    .timeout_o (mem_timeout)
  );

  // NOTE: every output and state_d gets a default first, so no path through
  // the case can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    ir_addr_out_en = 1'b0;
    reg_sel        = 2'd0;
    reg_out_en     = 1'b0;
    reg_in         = 1'b0;
    alu_a_in       = 1'b0;
    alu_op         = 2'd0;
    alu_z_in       = 1'b0;
    alu_out_en     = 1'b0;
    MARin          = 1'b0;
    EN             = 1'b0;
    RW             = 1'b0;
    MDR_tobusin    = 1'b0;
    MDR_frombusin  = 1'b0;
    MDROutEn       = 1'b0;
    PCin           = 1'b0;
    done           = 1'b0;
    halted         = 1'b0;
    fault          = 1'b0;

    case (state_q)
      S_IDLE: if (done_fetch) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode_q)
          OP_NOP:                        state_d = S_DONE;
          OP_LOAD:                       state_d = S_LD1;
          OP_STORE:                      state_d = S_ST1;
          OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_AL1;
          OP_LDI:                        state_d = S_LDI;
          OP_JMP:                        state_d = S_JMP;
          OP_HALT:                       state_d = S_HALTED;
          default:                       state_d = S_FAULT;
        endcase
      end
      S_LD1: begin
        ir_addr_out_en = 1'b1; MARin = 1'b1;
        state_d = S_LD2;
      end
      S_LD2: begin
        EN = 1'b1; RW = 1'b1;
        if (mem_ack)          state_d = S_LD3;
        else if (mem_timeout) state_d = S_FAULT;
      end
      S_LD3: begin
        MDR_tobusin = 1'b1; MDROutEn = 1'b1; reg_in = 1'b1; reg_sel = rd_q;
        state_d = S_DONE;
      end
      S_ST1: begin
        ir_addr_out_en = 1'b1; MARin = 1'b1;
        state_d = S_ST2;
      end
      S_ST2: begin
        reg_out_en = 1'b1; reg_sel = rd_q; MDR_frombusin = 1'b1;
        state_d = S_ST3;
      end
      S_ST3: begin
        EN = 1'b1;
        if (mem_ack)          state_d = S_DONE;
        else if (mem_timeout) state_d = S_FAULT;
      end
      S_AL1: begin
        reg_out_en = 1'b1; reg_sel = rd_q; alu_a_in = 1'b1;
        state_d = S_AL2;
      end
      S_AL2: begin
        reg_out_en = 1'b1; reg_sel = rs_q; alu_op = alu_fn(opcode_q); alu_z_in = 1'b1;
        state_d = S_AL3;
      end
      S_AL3: begin
        alu_out_en = 1'b1; reg_in = 1'b1; reg_sel = rd_q;
        state_d = S_DONE;
      end
      S_LDI: begin
        ir_addr_out_en = 1'b1; reg_in = 1'b1; reg_sel = rd_q;
        state_d = S_DONE;
      end
      S_JMP: begin
        ir_addr_out_en = 1'b1; PCin = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        state_d = S_IDLE;
      end
      S_HALTED: halted = 1'b1;
      S_FAULT: begin
        fault = 1'b1; halted = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_execute_fsm.sv
// Directed bench for execute_fsm: a reference model queues per-cycle stimulus
// and expected Moore outputs; each step is driven then compared one edge later.
module tb_execute_fsm;
  import exec_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        done_fetch = 1'b0;
  logic [15:0] ir = '0;
  logic        MFC = 1'b0;
  logic        ir_addr_out_en, reg_out_en, reg_in, alu_a_in, alu_z_in, alu_out_en;
  logic [1:0]  reg_sel, alu_op;
  logic        MARin, EN, RW, MDR_tobusin, MDR_frombusin, MDROutEn, PCin;
  logic        done, halted, fault;

  always #5 clk = ~clk;

  execute_fsm #(.IR_W(16), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .done_fetch(done_fetch), .ir(ir), .MFC(MFC),
    .ir_addr_out_en(ir_addr_out_en), .reg_sel(reg_sel), .reg_out_en(reg_out_en),
    .reg_in(reg_in), .alu_a_in(alu_a_in), .alu_op(alu_op), .alu_z_in(alu_z_in),
    .alu_out_en(alu_out_en), .MARin(MARin), .EN(EN), .RW(RW),
    .MDR_tobusin(MDR_tobusin), .MDR_frombusin(MDR_frombusin), .MDROutEn(MDROutEn),
    .PCin(PCin), .done(done), .halted(halted), .fault(fault)
  );

  typedef struct packed {
    logic       ir_addr_out_en;
    logic [1:0] reg_sel;
    logic       reg_out_en, reg_in, alu_a_in;
    logic [1:0] alu_op;
    logic       alu_z_in, alu_out_en, MARin, EN, RW;
    logic       MDR_tobusin, MDR_frombusin, MDROutEn, PCin;
    logic       done, halted, fault;
  } outs_t;

  typedef struct {
    string       tag;
    logic [15:0] ir;
    logic        df, mfc, rs;
    outs_t       exp;
  } step_t;

  outs_t obs;
  assign obs = {ir_addr_out_en, reg_sel, reg_out_en, reg_in, alu_a_in, alu_op,
                alu_z_in, alu_out_en, MARin, EN, RW, MDR_tobusin, MDR_frombusin,
                MDROutEn, PCin, done, halted, fault};

  step_t       sb[$];
  logic [15:0] pend_ir  = '0;
  logic        pend_df  = 1'b0;
  logic        pend_mfc = 1'b0;
  logic        pend_rst = 1'b0;
  int          n_checks = 0;
  int          n_pass   = 0;

  // Stimulus flags set before a push apply to the edge that produces that step.
  task automatic push(input string tag, input outs_t v);
    step_t e;
    e.tag = tag; e.ir = pend_ir; e.df = pend_df; e.mfc = pend_mfc; e.rs = pend_rst;
    e.exp = v;
    sb.push_back(e);
    pend_df = 1'b0; pend_mfc = 1'b0; pend_rst = 1'b0; pend_ir = '0;
  endtask

  task automatic fault_tail();
    outs_t v;
    v = '0; v.fault = 1'b1; v.halted = 1'b1;
    push("fault", v);
    push("fault_hold", v);
    pend_ir = 16'h7A5C; pend_df = 1'b1;
    push("fault_ignores_df", v);
    push("fault_sticky", v);
  endtask

  task automatic mem_wait(input string tag, input outs_t v, input int mfc_at,
                          output bit ok);
    int nw;
    nw = (mfc_at == 0) ? TIMEOUT : mfc_at;
    for (int k = 0; k < nw; k++) push(tag, v);
    if (mfc_at == 0) begin
      fault_tail();
      ok = 1'b0;
    end else begin
      pend_mfc = 1'b1;
      ok = 1'b1;
    end
  endtask

  // Reference model: expected output sequence from done_fetch sample onwards.
  task automatic issue(input logic [15:0] word, input int mfc_at);
    logic [3:0] opc;
    logic [1:0] rd, rs;
    outs_t      v;
    bit         ok;
    opc = word[15:12]; rd = word[11:10]; rs = word[9:8];
    pend_ir = word; pend_df = 1'b1;
    push("decode", '0);
    case (opc)
      4'd0: ;
      4'd1: begin
        v = '0; v.ir_addr_out_en = 1'b1; v.MARin = 1'b1; push("ld1", v);
        v = '0; v.EN = 1'b1; v.RW = 1'b1; mem_wait("ld2", v, mfc_at, ok);
        if (!ok) return;
        v = '0; v.MDR_tobusin = 1'b1; v.MDROutEn = 1'b1; v.reg_in = 1'b1; v.reg_sel = rd;
        push("ld3", v);
      end
      4'd2: begin
        v = '0; v.ir_addr_out_en = 1'b1; v.MARin = 1'b1; push("st1", v);
        v = '0; v.reg_out_en = 1'b1; v.reg_sel = rd; v.MDR_frombusin = 1'b1; push("st2", v);
        v = '0; v.EN = 1'b1; mem_wait("st3", v, mfc_at, ok);
        if (!ok) return;
      end
      4'd3, 4'd4, 4'd5, 4'd6: begin
        v = '0; v.reg_out_en = 1'b1; v.reg_sel = rd; v.alu_a_in = 1'b1; push("al1", v);
        v = '0; v.reg_out_en = 1'b1; v.reg_sel = rs; v.alu_z_in = 1'b1;
        v.alu_op = 2'(opc - 4'd3); push("al2", v);
        v = '0; v.alu_out_en = 1'b1; v.reg_in = 1'b1; v.reg_sel = rd; push("al3", v);
      end
      4'd7: begin
        v = '0; v.ir_addr_out_en = 1'b1; v.reg_in = 1'b1; v.reg_sel = rd; push("ldi", v);
      end
      4'd8: begin
        v = '0; v.ir_addr_out_en = 1'b1; v.PCin = 1'b1; push("jmp", v);
      end
      4'd15: begin
        v = '0; v.halted = 1'b1;
        push("halted", v);
        pend_ir = 16'h7A5C; pend_df = 1'b1;
        push("halted_ignores_df", v);
        push("halted_no_done", v);
        return;
      end
      default: begin
        fault_tail();
        return;
      end
    endcase
    v = '0; v.done = 1'b1;
    push("done", v);
    push("idle", '0);
  endtask

  task automatic reset_clear();
    pend_rst = 1'b1;
    push("rst_clears", '0);
    push("idle_after_rst", '0);
  endtask

  // Drain the scoreboard: drive at negedge, compare at the next negedge.
  task automatic run();
    step_t       e;
    logic [3:0]  drv;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rst = e.rs; done_fetch = e.df; MFC = e.mfc; ir = e.ir;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      assert (obs === e.exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      drv = {ir_addr_out_en, reg_out_en, alu_out_en, MDROutEn};
      n_checks++;
      assert ($onehot0(drv) === 1'b1) n_pass++;
      else $error("FAIL bus_%s: drivers %b expected one-hot-or-zero", e.tag, drv);
    end
    rst = 1'b0; done_fetch = 1'b0; MFC = 1'b0;
  endtask

  initial begin
    outs_t v;
    @(negedge clk);
    pend_rst = 1'b1; push("reset", '0);
    pend_rst = 1'b1; push("reset_hold", '0);
    run();

    issue(16'h7A5C, 0); run();   // LDI r2,0x5C
    issue(16'h1342, 4); run();   // LOAD, MFC on 4th wait cycle
    issue(16'h4600, 0); run();   // SUB r1,r2
    issue(16'h3C00, 0); run();   // ADD r3,r0
    issue(16'h6900, 0); run();   // OR r2,r1
    issue(16'h0000, 0); run();   // NOP
    issue(16'h8012, 0); run();   // JMP
    issue(16'h1342, 1); run();   // LOAD, minimum one wait cycle
    issue(16'h1C42, TIMEOUT); run(); // LOAD r3: MFC on last cycle beats timeout
    issue(16'h2140, 2); run();   // STORE, normal completion

    issue(16'h2140, 0); reset_clear(); run();  // STORE timeout -> FAULT
    issue(16'hF000, 0); reset_clear(); run();  // HALT
    issue(16'hB000, 0); reset_clear(); run();  // illegal opcode

    // Reset in the 2nd LD2 wait cycle with MFC high on the same cycle.
    pend_ir = 16'h1342; pend_df = 1'b1; push("decode", '0);
    v = '0; v.ir_addr_out_en = 1'b1; v.MARin = 1'b1; push("ld1", v);
    v = '0; v.EN = 1'b1; v.RW = 1'b1;   push("ld2_1", v); push("ld2_2", v);
    pend_rst = 1'b1; pend_mfc = 1'b1;   push("rst_mid_ld2", '0);
    push("idle_after_mid_rst", '0);
    run();
    issue(16'h7D33, 0); run();   // LDI r3 after reset

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
